// File: rtl/pmem_bus_pkg.sv
// Shared definitions for the pmem responder: bus widths, response codes,
// FSM states and the address-window helper.
package pmem_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_RESP,
    WR_WAIT,
    WR_RESP
  } state_t;

  // Evaluated in 33 bits so a window ending at 0xFFFF_FFFF does not wrap.
  function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base,
                                     input logic [ADDR_W-1:0] size);
    logic [ADDR_W:0] a;
    logic [ADDR_W:0] lo;
    logic [ADDR_W:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + {1'b0, size} - {{ADDR_W{1'b0}}, 1'b1};
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/pmem_dpi_pkg.sv
// Single shared home of the pmem_read/pmem_write memory entry points, here as a
// word-addressed behavioural memory with call counters for simulation.
package pmem_dpi_pkg;

  logic [31:0] pmem_words [logic [29:0]];
  int unsigned pmem_read_calls;
  int unsigned pmem_write_calls;
  int unsigned pmem_fetch_calls;

  // Side-effect-free lookup; unwritten words read as zero.
  function automatic logic [31:0] pmem_peek(input logic [31:0] addr);
    if (pmem_words.exists(addr[31:2])) return pmem_words[addr[31:2]];
    return 32'h0;
  endfunction

  function automatic int pmem_read(input int raddr, input int flag);
    logic [31:0] a;
    a = raddr;
    pmem_read_calls++;
    if (flag != 0) pmem_fetch_calls++;
    return int'(pmem_peek(a));
  endfunction

  function automatic void pmem_write(input int waddr, input int wdata, input int wmask);
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] m;
    logic [31:0] word;
    a    = waddr;
    d    = wdata;
    m    = wmask;
    word = pmem_peek(a);
    for (int b = 0; b < 4; b++) begin
      if (m[b]) word[8*b +: 8] = d[8*b +: 8];
    end
    pmem_words[a[31:2]] = word;
    pmem_write_calls++;
  endfunction

endpackage

// File: rtl/pmem_responder_latency_counter.sv
// Down-counter loaded with LATENCY on start; done is high whenever it sits at zero.
module latency_counter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = 4'(LATENCY);
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 4'd0;
    else     cnt_q <= cnt_d;
  end

  assign done = (cnt_q == 4'd0);

endmodule

// File: rtl/pmem_responder.sv
// Single-outstanding AXI4-Lite-style memory responder with programmable
// response latency in front of the pmem_read/pmem_write memory model.
module pmem_responder
  import pmem_bus_pkg::*;
  import pmem_dpi_pkg::*;
#(
  parameter int unsigned   LATENCY  = 1,
  parameter logic [31:0]   MEM_BASE = 32'h8000_0000,
  parameter logic [31:0]   MEM_SIZE = 32'h0800_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arflag,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ar_addr_q, ar_addr_d;
  logic                ar_flag_q, ar_flag_d;
  logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                aw_held_q, aw_held_d;
  logic                w_held_q, w_held_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                cnt_start;
  logic                cnt_done;
  logic                rd_in_win;
  logic                wr_in_win;
  logic                rd_fire;
  logic                wr_fire;

  latency_counter #(.LATENCY(LATENCY)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .start (cnt_start),
    .done  (cnt_done)
  );

  assign rd_in_win = in_window(ar_addr_q, MEM_BASE, MEM_SIZE);
  assign wr_in_win = in_window(aw_addr_q, MEM_BASE, MEM_SIZE);
  assign rd_fire   = (state_q == RD_WAIT) && cnt_done && rd_in_win;
  assign wr_fire   = (state_q == WR_WAIT) && cnt_done && wr_in_win;

  // A pending read blocks write-channel acceptance in the same cycle.
  assign arready = (state_q == IDLE) && !rst;
  assign awready = (state_q == IDLE) && !rst && !arvalid && !aw_held_q;
  assign wready  = (state_q == IDLE) && !rst && !arvalid && !w_held_q;
  assign rvalid  = (state_q == RD_RESP);
  assign bvalid  = (state_q == WR_RESP);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign bresp   = bresp_q;

  always_comb begin
    state_d   = state_q;
    ar_addr_d = ar_addr_q;
    ar_flag_d = ar_flag_q;
    aw_addr_d = aw_addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    bresp_d   = bresp_q;
    cnt_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (arvalid) begin
          ar_addr_d = araddr;
          ar_flag_d = arflag;
          state_d   = RD_WAIT;
          cnt_start = 1'b1;
        end else begin
          if (awvalid && !aw_held_q) begin
            aw_addr_d = awaddr;
            aw_held_d = 1'b1;
          end
          if (wvalid && !w_held_q) begin
            wdata_d  = wdata;
            wstrb_d  = wstrb;
            w_held_d = 1'b1;
          end
          if (aw_held_d && w_held_d) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            state_d   = WR_WAIT;
            cnt_start = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_done) begin
          state_d = RD_RESP;
          rresp_d = rd_in_win ? RESP_OKAY : RESP_DECERR;
          if (!rd_in_win) rdata_d = '0;
        end
      end
      RD_RESP: if (rready) state_d = IDLE;
      WR_WAIT: begin
        if (cnt_done) begin
          state_d = WR_RESP;
          bresp_d = wr_in_win ? RESP_OKAY : RESP_DECERR;
        end
      end
      WR_RESP: if (bready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory calls sit on the clock edge so each fires exactly once per access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ar_addr_q <= '0;
      ar_flag_q <= 1'b0;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      bresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      ar_addr_q <= ar_addr_d;
      ar_flag_q <= ar_flag_d;
      aw_addr_q <= aw_addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      rresp_q   <= rresp_d;
      bresp_q   <= bresp_d;
      if (rd_fire) rdata_q <= pmem_read(int'(ar_addr_q), int'({31'b0, ar_flag_q}));
      else         rdata_q <= rdata_d;
      if (wr_fire) pmem_write(int'(aw_addr_q), int'(wdata_q), int'({28'b0, wstrb_q}));
    end
  end

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: a table of single transactions plus
// hand-written sequences for ordering, back-pressure and mid-transaction reset.
module tb_pmem_responder;
  import pmem_bus_pkg::*;
  import pmem_dpi_pkg::*;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arflag;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  always #5 clk = ~clk;

  pmem_responder #(
    .LATENCY  (LAT),
    .MEM_BASE (32'h8000_0000),
    .MEM_SIZE (32'h0800_0000)
  ) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arflag(arflag), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_calls;
  } vec_t;

  vec_t vecs [11];
  int   total;
  int   bad;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_rvalid(output int n);
    n = 0;
    do begin
      @(posedge clk); n++; @(negedge clk);
    end while (!rvalid && n < 40);
  endtask

  task automatic wait_bvalid(output int n);
    n = 0;
    do begin
      @(posedge clk); n++; @(negedge clk);
    end while (!bvalid && n < 40);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic flag,
                         output logic [31:0] data, output logic [1:0] resp, output int n);
    @(posedge clk); #1;
    araddr = addr; arflag = flag; arvalid = 1'b1;
    @(negedge clk);
    check("read arready", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    wait_rvalid(n);
    data = rdata; resp = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int n);
    @(posedge clk); #1;
    awaddr = addr; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    @(negedge clk);
    check("write aw/w ready", 32'({awready, wready}), 32'd3);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    wait_bvalid(n);
    resp = bresp;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          n;
    int unsigned snap;

    total = 0; bad = 0;
    rst = 1'b1;
    araddr = '0; arflag = 1'b0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    pmem_write(int'(32'h8000_0000), int'(32'h0000_0413), 15);

    vecs[0]  = '{1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0000_0413, RESP_OKAY,   1};
    vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'h0000_BEEF, RESP_OKAY,   1};
    vecs[2]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 32'h0, RESP_OKAY,   1};
    vecs[3]  = '{1'b0, 32'h8000_0020, 32'h0, 4'h0, 32'h1122_3344, RESP_OKAY,   1};
    vecs[4]  = '{1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'hA, 32'h0, RESP_OKAY,   1};
    vecs[5]  = '{1'b0, 32'h8000_0020, 32'h0, 4'h0, 32'hAA22_CC44, RESP_OKAY,   1};
    vecs[6]  = '{1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0,         RESP_DECERR, 0};
    vecs[7]  = '{1'b0, 32'h8800_0000, 32'h0, 4'h0, 32'h0,         RESP_DECERR, 0};
    vecs[8]  = '{1'b1, 32'h8800_0000, 32'h1234_5678, 4'hF, 32'h0, RESP_DECERR, 0};
    vecs[9]  = '{1'b0, 32'h87FF_FFFC, 32'h0, 4'h0, 32'h0,         RESP_OKAY,   1};
    vecs[10] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 4'hF, 32'h0, RESP_DECERR, 0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ready/valid", 32'({arready, awready, wready, rvalid, bvalid}), 32'd0);
    check("reset data/resp", 32'({rresp, bresp}) | rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle readies", 32'({arready, awready, wready, rvalid, bvalid}), 32'b11100);

    // AW first, W one cycle later
    snap = pmem_write_calls;
    @(posedge clk); #1;
    awaddr = 32'h8000_0010; awvalid = 1'b1;
    @(negedge clk);
    check("seqB awready", 32'(awready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wdata = 32'hDEAD_BEEF; wstrb = 4'b0011; wvalid = 1'b1;
    @(negedge clk);
    check("seqB aw held/wready", 32'({awready, wready}), 32'b01);
    @(posedge clk); #1;
    wvalid = 1'b0;
    wait_bvalid(n);
    check("seqB latency", 32'(n), 32'(LAT + 1));
    check("seqB bresp", 32'(bresp), 32'(RESP_OKAY));
    check("seqB write calls", pmem_write_calls - snap, 32'd1);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    $display("seqB write 80000010 bresp=%0d latency=%0d", bresp, n);

    // Table-driven transactions
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].wr) begin
        snap = pmem_write_calls;
        do_write(vecs[i].addr, vecs[i].wd, vecs[i].strb, r, n);
        check($sformatf("vec%0d write calls", i), pmem_write_calls - snap, 32'(vecs[i].exp_calls));
        $display("vec%0d W addr=%h data=%h strb=%h resp=%0d lat=%0d", i, vecs[i].addr, vecs[i].wd, vecs[i].strb, r, n);
      end else begin
        snap = pmem_read_calls;
        do_read(vecs[i].addr, 1'b0, d, r, n);
        check($sformatf("vec%0d rdata", i), d, vecs[i].exp_rdata);
        check($sformatf("vec%0d read calls", i), pmem_read_calls - snap, 32'(vecs[i].exp_calls));
        $display("vec%0d R addr=%h rdata=%h resp=%0d lat=%0d", i, vecs[i].addr, d, r, n);
      end
      check($sformatf("vec%0d resp", i), 32'(r), 32'(vecs[i].exp_resp));
      check($sformatf("vec%0d latency", i), 32'(n), 32'(LAT + 1));
    end

    // AR, AW and W together: read wins, write follows the R handshake
    @(posedge clk); #1;
    araddr = 32'h8000_0000; arflag = 1'b1; arvalid = 1'b1;
    awaddr = 32'h8000_0030; awvalid = 1'b1; wdata = 32'h5566_7788; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    check("seqC ar/aw/w ready", 32'({arready, awready, wready}), 32'b100);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check("seqC no write accept in read", 32'({awready, wready}), 32'd0);
    wait_rvalid(n);
    check("seqC read latency", 32'(n), 32'(LAT + 1));
    check("seqC rdata", rdata, 32'h0000_0413);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    @(negedge clk);
    check("seqC write readies after R", 32'({awready, wready}), 32'b11);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    wait_bvalid(n);
    check("seqC write latency", 32'(n), 32'(LAT + 1));
    check("seqC bresp", 32'(bresp), 32'(RESP_OKAY));
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("seqC memory word", pmem_peek(32'h8000_0030), 32'h5566_7788);
    $display("seqC read-then-write latency=%0d", n);

    // Back-pressure on R
    @(posedge clk); #1;
    araddr = 32'h8000_0000; arflag = 1'b0; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    wait_rvalid(n);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("seqD hold%0d rvalid/arready", k), 32'({rvalid, arready}), 32'b10);
      check($sformatf("seqD hold%0d rdata", k), rdata, 32'h0000_0413);
      @(negedge clk);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    $display("seqD rready held low 5 cycles rdata=%h", rdata);

    // Leave nonzero rdata/bresp behind, then reset during WR_WAIT
    do_write(32'h9000_0000, 32'h0, 4'hF, r, n);
    check("seqE decerr bresp", 32'(r), 32'(RESP_DECERR));
    snap = pmem_write_calls;
    @(posedge clk); #1;
    awaddr = 32'h8000_0000; awvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("seqE reset ready/valid", 32'({arready, awready, wready, rvalid, bvalid}), 32'd0);
    check("seqE reset rdata", rdata, 32'd0);
    check("seqE reset resp", 32'({rresp, bresp}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("seqE no bvalid %0d", k), 32'(bvalid), 32'd0);
    end
    check("seqE back to idle", 32'({arready, awready, wready}), 32'b111);
    check("seqE write calls", pmem_write_calls - snap, 32'd0);
    check("seqE memory unchanged", pmem_peek(32'h8000_0000), 32'h0000_0413);
    $display("seqE reset during WR_WAIT word=%h", pmem_peek(32'h8000_0000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
